frame_buffer_pixel_unpack: RTL and testbench

FRAME_BUFFER_PIXEL_UNPACK -- requirements
Module: frame_buffer_pixel_unpack

---
 rtl/frame_buffer_pixel_unpack.sv | 126 ++++++++++++
 tb/tb_frame_buffer_pixel_unpack.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_pixel_unpack.sv
// Frame-buffer pixel unpacker: byte FIFO that turns raw memory words into
// beats of up to C_MAX_PORT_NUM pixels of MEM_BYTES stored bytes each.
// Ports: VID_CLK_I/VID_RSTN_I clock and async active-low reset;
//   SOF_I, MEM_BYTES_I, PORT_NUM_I frame start and per-frame config;
//   RAW_DATA_I/RAW_VALID_I/RAW_RD_O first-word-fall-through word input;
//   PIX_REQ_I/PIX_DATA_O/PIX_VALID_O beat request and registered beat;
//   UNDERFLOW_O sticky short-request flag; CFG_ERR_O illegal config flag.
module frame_buffer_pixel_unpack #(
    parameter int C_RAW_DATA_WIDTH         = 256,
    parameter int C_MAX_PORT_NUM           = 4,
    parameter int C_DDR_PIXEL_MAX_BYTE_NUM = 4
) (
    input  logic                        VID_CLK_I,
    input  logic                        VID_RSTN_I,
    input  logic                        SOF_I,
    input  logic [2:0]                  MEM_BYTES_I,
    input  logic [3:0]                  PORT_NUM_I,
    input  logic [C_RAW_DATA_WIDTH-1:0] RAW_DATA_I,
    input  logic                        RAW_VALID_I,
    output logic                        RAW_RD_O,
    input  logic                        PIX_REQ_I,
    output logic [C_DDR_PIXEL_MAX_BYTE_NUM*8*C_MAX_PORT_NUM-1:0] PIX_DATA_O,
    output logic                        PIX_VALID_O,
    output logic                        UNDERFLOW_O,
    output logic                        CFG_ERR_O
);

    localparam int B   = C_DDR_PIXEL_MAX_BYTE_NUM;
    localparam int P   = C_MAX_PORT_NUM;
    localparam int PW  = B * 8 * P;
    localparam int WB  = C_RAW_DATA_WIDTH / 8;
    localparam int BUF = 2 * WB;
    localparam logic [15:0] BUF_N = 16'(BUF);
    localparam logic [15:0] WB_N  = 16'(WB);

    // Byte 0 of buf_q is always the oldest byte; bytes at or above cnt_q
    // are kept at zero so a new word can simply be OR-ed in.
    logic [BUF*8-1:0] buf_q, buf_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       mb_q;
    logic [3:0]       pn_q;
    logic             cfg_err_q;
    logic             run_q;
    logic             pix_valid_q;
    logic             underflow_q;
    logic [PW-1:0]    pix_data_q, pix_d;

    logic [15:0] need, popped, keep, off;
    logic        pop, short, load, cfg_bad;

    always_comb begin
        need    = 16'(mb_q) * 16'(pn_q);
        pop     = PIX_REQ_I && !SOF_I && !cfg_err_q && (cnt_q >= need);
        short   = PIX_REQ_I && !SOF_I && !cfg_err_q && (cnt_q < need);
        popped  = pop ? need : 16'd0;
        keep    = cnt_q - popped;
        // run_q holds the read off until the first edge after reset.
        load    = RAW_VALID_I && !SOF_I && !cfg_err_q && run_q &&
                  (keep + WB_N <= BUF_N);
        cnt_d   = load ? keep + WB_N : keep;
        buf_d   = buf_q >> {popped, 3'b000};
        if (load) begin
            buf_d = buf_d |
                ({{(BUF*8-C_RAW_DATA_WIDTH){1'b0}}, RAW_DATA_I}
                 << {keep, 3'b000});
        end
        cfg_bad = (MEM_BYTES_I == 3'd0) || (int'(MEM_BYTES_I) > B) ||
                  (PORT_NUM_I == 4'd0) || (int'(PORT_NUM_I) > P);
    end

    // Pixel p byte k comes from head byte p*MEM_BYTES+k; unused lanes are 0.
    always_comb begin
        pix_d = '0;
        off   = '0;
        for (int p = 0; p < P; p++) begin
            for (int k = 0; k < B; k++) begin
                off = 16'(p) * 16'(mb_q) + 16'(k);
                if (p < int'(pn_q) && k < int'(mb_q)) begin
                    pix_d[(p*B+k)*8 +: 8] = 8'(buf_q >> {off, 3'b000});
                end
            end
        end
    end

    always_ff @(posedge VID_CLK_I or negedge VID_RSTN_I) begin
        if (!VID_RSTN_I) begin
            buf_q       <= '0;
            cnt_q       <= '0;
            mb_q        <= 3'(B);
            pn_q        <= 4'(P);
            cfg_err_q   <= 1'b0;
            run_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (SOF_I) begin
                buf_q       <= '0;
                cnt_q       <= '0;
                mb_q        <= MEM_BYTES_I;
                pn_q        <= PORT_NUM_I;
                cfg_err_q   <= cfg_bad;
                pix_valid_q <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                buf_q       <= buf_d;
                cnt_q       <= cnt_d;
                pix_valid_q <= pop;
                if (pop) begin
                    pix_data_q <= pix_d;
                end
                if (short) begin
                    underflow_q <= 1'b1;
                end
            end
        end
    end

    assign RAW_RD_O    = load;
    assign PIX_DATA_O  = pix_data_q;
    assign PIX_VALID_O = pix_valid_q;
    assign UNDERFLOW_O = underflow_q;
    assign CFG_ERR_O   = cfg_err_q;

endmodule

// File: tb/tb_frame_buffer_pixel_unpack.sv
// Testbench for frame_buffer_pixel_unpack: byte-queue reference model,
// directed frame scenarios plus randomized request/valid traffic.
module tb_frame_buffer_pixel_unpack;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         sof;
    logic [2:0]   mem_bytes;
    logic [3:0]   port_num;
    logic [255:0] raw_data;
    logic         raw_valid;
    logic         raw_rd;
    logic         pix_req;
    logic [127:0] pix_data;
    logic         pix_valid;
    logic         underflow;
    logic         cfg_err;

    frame_buffer_pixel_unpack dut (
        .VID_CLK_I   (clk),
        .VID_RSTN_I  (rst_n),
        .SOF_I       (sof),
        .MEM_BYTES_I (mem_bytes),
        .PORT_NUM_I  (port_num),
        .RAW_DATA_I  (raw_data),
        .RAW_VALID_I (raw_valid),
        .RAW_RD_O    (raw_rd),
        .PIX_REQ_I   (pix_req),
        .PIX_DATA_O  (pix_data),
        .PIX_VALID_O (pix_valid),
        .UNDERFLOW_O (underflow),
        .CFG_ERR_O   (cfg_err)
    );

    always #5 clk = ~clk;

    // reference model: the buffer is just a queue of bytes
    byte unsigned q[$];
    int           m_mb, m_pn;
    bit           m_err, m_uf, m_run;
    bit           exp_valid, exp_rd, obs_rd;
    logic [127:0] exp_data;
    int           pat;
    bit           rand_data;
    int           loaded_words;
    int           mm_rd, mm_v, mm_d, mm_u, mm_e;
    int           n_checks, n_fail;

    task automatic model_reset();
        q.delete();
        m_mb = 4; m_pn = 4;
        m_err = 0; m_uf = 0; m_run = 0;
        exp_valid = 0; exp_data = '0;
    endtask

    task automatic clr_mm();
        mm_rd = 0; mm_v = 0; mm_d = 0; mm_u = 0; mm_e = 0;
    endtask

    // One clock: drive at negedge, advance model at posedge, tally
    // model/DUT disagreements at the following negedge.
    task automatic step(input bit s, input int mb, input int pn,
                        input bit vld, input bit req);
        logic [255:0] w;
        int need;
        bit pop;
        for (int i = 0; i < 32; i++)
            w[i*8 +: 8] = rand_data ? 8'($urandom) : 8'(pat + i);
        sof = s; mem_bytes = 3'(mb); port_num = 4'(pn);
        raw_valid = vld; pix_req = req; raw_data = w;
        #1;
        need = m_mb * m_pn;
        pop = req && !s && !m_err && (q.size() >= need);
        exp_rd = vld && !s && !m_err && m_run &&
                 (q.size() - (pop ? need : 0) + 32 <= 64);
        obs_rd = raw_rd;
        if (obs_rd !== exp_rd) mm_rd++;
        @(posedge clk);
        m_run = 1;
        if (s) begin
            q.delete();
            m_mb = mb; m_pn = pn;
            m_err = (mb < 1 || mb > 4 || pn < 1 || pn > 4);
            m_uf = 0; exp_valid = 0; loaded_words = 0;
        end else begin
            exp_valid = pop;
            if (pop) begin
                exp_data = '0;
                for (int p = 0; p < m_pn; p++)
                    for (int k = 0; k < m_mb; k++)
                        exp_data[(p*4+k)*8 +: 8] = q[p*m_mb+k];
                for (int i = 0; i < need; i++) void'(q.pop_front());
            end else if (req && !m_err) begin
                m_uf = 1;
            end
            if (exp_rd) begin
                for (int i = 0; i < 32; i++) q.push_back(w[i*8 +: 8]);
                pat += 32;
                loaded_words++;
            end
        end
        @(negedge clk);
        if (pix_valid !== exp_valid) mm_v++;
        if (pix_data !== exp_data) mm_d++;
        if (underflow !== m_uf) mm_u++;
        if (cfg_err !== m_err) mm_e++;
    endtask

    task automatic test_reset();
        clr_mm();
        rst_n = 0; sof = 0; mem_bytes = 3'd4; port_num = 4'd4;
        raw_data = '1; raw_valid = 1; pix_req = 1;
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({raw_rd, pix_valid, underflow, cfg_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: rd/vld/uf/err=%b required 0000",
                     {raw_rd, pix_valid, underflow, cfg_err});
        end
        n_checks++;
        if (pix_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: %h required 0", pix_data);
        end
        rst_n = 1;
        step(0, 4, 4, 1, 0);
        n_checks++;
        if (obs_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_before_first_edge: %b required 0", obs_rd);
        end
        step(0, 4, 4, 1, 0);
        n_checks++;
        if (obs_rd !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_after_first_edge: %b required 1", obs_rd);
        end
        n_checks++;
        if (mm_rd + mm_v + mm_d + mm_u + mm_e != 0) begin
            n_fail++;
            $display("FAIL reset_model: rd%0d v%0d d%0d u%0d e%0d required 0",
                     mm_rd, mm_v, mm_d, mm_u, mm_e);
        end
    endtask

    task automatic test_4x4_stream();
        int beats, bad;
        logic [31:0] e;
        clr_mm(); pat = 0; beats = 0; bad = 0;
        step(1, 4, 4, 0, 0);
        step(0, 4, 4, 1, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 4, 4, 1, 1);
            if (pix_valid === 1'b1) begin
                for (int k = 0; k < 4; k++) e[k*8 +: 8] = 8'(16*beats + k);
                if (pix_data[31:0] !== e) bad++;
                beats++;
            end
        end
        n_checks++;
        if (beats != 16) begin
            n_fail++;
            $display("FAIL s4x4_beats: %0d required 16", beats);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL s4x4_pixel0: %0d bad beats required 0", bad);
        end
        n_checks++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL s4x4_underflow: %b required 0", underflow);
        end
        n_checks++;
        if (mm_rd + mm_v + mm_d + mm_u + mm_e != 0) begin
            n_fail++;
            $display("FAIL s4x4_model: rd%0d v%0d d%0d u%0d e%0d required 0",
                     mm_rd, mm_v, mm_d, mm_u, mm_e);
        end
    endtask

    task automatic test_3x4_straddle();
        int beats, bad;
        logic [127:0] e;
        clr_mm(); pat = 0; beats = 0; bad = 0;
        step(1, 3, 4, 0, 0);
        step(0, 3, 4, 1, 0);
        for (int i = 0; i < 14; i++) begin
            step(0, 3, 4, loaded_words < 3, 1);
            if (pix_valid === 1'b1) begin
                e = '0;
                for (int p = 0; p < 4; p++)
                    for (int k = 0; k < 3; k++)
                        e[(p*4+k)*8 +: 8] = 8'(12*beats + 3*p + k);
                if (pix_data !== e) bad++;
                beats++;
            end
        end
        n_checks++;
        if (beats != 8) begin
            n_fail++;
            $display("FAIL s3x4_beats: %0d required 8", beats);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL s3x4_data: %0d bad beats required 0", bad);
        end
        n_checks++;
        if (mm_rd + mm_v + mm_d + mm_u + mm_e != 0) begin
            n_fail++;
            $display("FAIL s3x4_model: rd%0d v%0d d%0d u%0d e%0d required 0",
                     mm_rd, mm_v, mm_d, mm_u, mm_e);
        end
    endtask

    task automatic test_backpressure();
        int beats, bad, stalls;
        logic [127:0] e;
        clr_mm(); pat = 0; beats = 0; bad = 0; stalls = 0;
        step(1, 4, 2, 0, 0);
        for (int i = 0; i < 64; i++) begin
            step(0, 4, 2, 1, (i % 4) == 3);
            if (obs_rd === 1'b0) stalls++;
            if (pix_valid === 1'b1) begin
                e = '0;
                for (int j = 0; j < 8; j++) e[j*8 +: 8] = 8'(8*beats + j);
                if (pix_data !== e) bad++;
                beats++;
            end
        end
        n_checks++;
        if (beats != 16) begin
            n_fail++;
            $display("FAIL bp_beats: %0d required 16", beats);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_data: %0d bad beats required 0", bad);
        end
        n_checks++;
        if (stalls == 0) begin
            n_fail++;
            $display("FAIL bp_stall: %0d stall cycles required >0", stalls);
        end
        n_checks++;
        if (mm_rd + mm_v + mm_d + mm_u + mm_e != 0) begin
            n_fail++;
            $display("FAIL bp_model: rd%0d v%0d d%0d u%0d e%0d required 0",
                     mm_rd, mm_v, mm_d, mm_u, mm_e);
        end
    endtask

    task automatic test_underflow();
        int seen;
        clr_mm(); seen = 0;
        step(1, 4, 4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 4, 4, 0, 1);
            if (pix_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL uf_valid: %0d beats required 0", seen);
        end
        step(0, 4, 4, 0, 0);
        n_checks++;
        if (underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_sticky: %b required 1", underflow);
        end
        step(1, 4, 4, 0, 0);
        n_checks++;
        if (underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL uf_sof_clear: %b required 0", underflow);
        end
    endtask

    task automatic test_sof_mid();
        clr_mm();
        step(1, 4, 1, 0, 0);
        step(0, 4, 1, 1, 0);
        repeat (3) step(0, 4, 1, 0, 1);
        step(1, 4, 4, 1, 1);
        n_checks++;
        if (pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sof_req_ignored: valid=%b required 0", pix_valid);
        end
        pat = 160;
        step(0, 4, 4, 1, 0);
        step(0, 4, 4, 0, 1);
        n_checks++;
        if (pix_valid !== 1'b1 || pix_data[31:0] !== 32'hA3A2A1A0) begin
            n_fail++;
            $display("FAIL sof_restart: valid=%b px0=%h required 1 a3a2a1a0",
                     pix_valid, pix_data[31:0]);
        end
        step(1, 4, 0, 1, 0);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_set: %b required 1", cfg_err);
        end
        step(0, 4, 0, 1, 1);
        n_checks++;
        if (obs_rd !== 1'b0 || pix_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_block: rd=%b valid=%b required 0 0",
                     obs_rd, pix_valid);
        end
        step(1, 2, 2, 0, 0);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_clear: %b required 0", cfg_err);
        end
        n_checks++;
        if (mm_rd + mm_v + mm_d + mm_u + mm_e != 0) begin
            n_fail++;
            $display("FAIL sof_model: rd%0d v%0d d%0d u%0d e%0d required 0",
                     mm_rd, mm_v, mm_d, mm_u, mm_e);
        end
    endtask

    task automatic test_random();
        int mb, pn, beats;
        clr_mm(); rand_data = 1; beats = 0;
        for (int r = 0; r < 6; r++) begin
            mb = int'($urandom_range(1, 4));
            pn = int'($urandom_range(1, 4));
            step(1, mb, pn, 0, 0);
            for (int i = 0; i < 60; i++) begin
                step(0, mb, pn, ($urandom % 4) != 0, $urandom % 2);
                if (pix_valid === 1'b1) beats++;
            end
        end
        rand_data = 0;
        n_checks++;
        if (beats == 0) begin
            n_fail++;
            $display("FAIL rand_beats: %0d required >0", beats);
        end
        n_checks++;
        if (mm_rd + mm_v + mm_d + mm_u + mm_e != 0) begin
            n_fail++;
            $display("FAIL rand_model: rd%0d v%0d d%0d u%0d e%0d required 0",
                     mm_rd, mm_v, mm_d, mm_u, mm_e);
        end
    endtask

    task automatic test_reset_mid();
        clr_mm(); pat = 16;
        step(1, 4, 4, 0, 0);
        step(0, 4, 4, 1, 0);
        step(0, 4, 4, 1, 1);
        #2;
        rst_n = 0;
        #1;
        n_checks++;
        if ({raw_rd, pix_valid, underflow, cfg_err} !== 4'b0 ||
            pix_data !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: rd/vld/uf/err=%b data=%h required 0",
                     {raw_rd, pix_valid, underflow, cfg_err}, pix_data);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step(1, 4, 4, 0, 0);
        pat = 64;
        step(0, 4, 4, 1, 0);
        step(0, 4, 4, 1, 1);
        n_checks++;
        if (pix_valid !== 1'b1 || pix_data[31:0] !== 32'h43424140) begin
            n_fail++;
            $display("FAIL mid_resume: valid=%b px0=%h required 1 43424140",
                     pix_valid, pix_data[31:0]);
        end
        n_checks++;
        if (mm_rd + mm_v + mm_d + mm_u + mm_e != 0) begin
            n_fail++;
            $display("FAIL mid_model: rd%0d v%0d d%0d u%0d e%0d required 0",
                     mm_rd, mm_v, mm_d, mm_u, mm_e);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        pat = 0; rand_data = 0; loaded_words = 0;
        test_reset();
        test_4x4_stream();
        test_3x4_straddle();
        test_backpressure();
        test_underflow();
        test_sof_mid();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
